// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse letter sequencer.
package morse_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StMark  = 2'b01,
        StSpace = 2'b10
    } state_e;

    localparam logic SymDot  = 1'b0;
    localparam logic SymDash = 1'b1;

endpackage

// File: rtl/run_len_counter.sv
// Saturating run-length counter: clear loads 1 (first cycle of a run), enable counts up.
module run_len_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= CNT_W'(1);
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/morse_letter_sequencer.sv
// Groups dot/dash marks on a keying line into letters and hands each finished
// letter to a one-entry valid/ready output register.
module morse_letter_sequencer
    import morse_pkg::*;
#(
    parameter int unsigned DASH_MIN = 3,
    parameter int unsigned GAP_MIN  = 3,
    parameter int unsigned MAX_SYMS = 5,
    parameter int unsigned CNT_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in,
    output logic [MAX_SYMS-1:0] code,
    output logic [2:0]          len,
    output logic                err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                ovf,
    output logic [1:0]          current_state
);

    state_e state_q, state_d;

    logic [CNT_W-1:0] mark_cnt, space_cnt;
    logic             mark_clr, mark_en, space_clr, space_en;

    logic [MAX_SYMS-1:0] acc_q, acc_d;
    logic [2:0]          nsym_q, nsym_d;
    logic                lerr_q, lerr_d;

    logic                complete, sym, load;
    logic [MAX_SYMS-1:0] let_code;
    logic [2:0]          let_len;
    logic                let_err;

    logic [MAX_SYMS-1:0] code_q;
    logic [2:0]          len_q;
    logic                err_q, out_valid_q, ovf_q;

    run_len_counter #(.CNT_W(CNT_W)) u_mark_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (mark_clr),
        .en_i  (mark_en),
        .cnt_o (mark_cnt)
    );

    run_len_counter #(.CNT_W(CNT_W)) u_space_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (space_clr),
        .en_i  (space_en),
        .cnt_o (space_cnt)
    );

    always_comb begin
        state_d   = state_q;
        mark_clr  = 1'b0;
        mark_en   = 1'b0;
        space_clr = 1'b0;
        space_en  = 1'b0;
        acc_d     = acc_q;
        nsym_d    = nsym_q;
        lerr_d    = lerr_q;
        complete  = 1'b0;
        sym       = (mark_cnt >= CNT_W'(DASH_MIN)) ? SymDash : SymDot;

        case (state_q)
            StIdle: begin
                if (in) begin
                    state_d  = StMark;
                    mark_clr = 1'b1;
                end
            end
            StMark: begin
                if (in) begin
                    mark_en = 1'b1;
                end else begin
                    if (nsym_q < 3'(MAX_SYMS)) begin
                        for (int unsigned i = 0; i < MAX_SYMS; i++) begin
                            if (3'(i) == nsym_q) acc_d[i] = sym;
                        end
                        nsym_d = nsym_q + 3'd1;
                    end else begin
                        lerr_d = 1'b1;
                    end
                    // A one-cycle gap threshold ends the letter on the falling edge itself.
                    if (GAP_MIN == 1) begin
                        complete = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        state_d   = StSpace;
                        space_clr = 1'b1;
                    end
                end
            end
            StSpace: begin
                if (in && (space_cnt < CNT_W'(GAP_MIN))) begin
                    state_d  = StMark;
                    mark_clr = 1'b1;
                end else if (!in && (space_cnt == CNT_W'(GAP_MIN - 1))) begin
                    complete = 1'b1;
                    state_d  = StIdle;
                end else begin
                    space_en = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        let_code = acc_d;
        let_len  = nsym_d;
        let_err  = lerr_d;
        if (complete) begin
            acc_d  = '0;
            nsym_d = '0;
            lerr_d = 1'b0;
        end
    end

    // Register is free if empty or being drained on this same edge.
    assign load = complete && (!out_valid_q || out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            nsym_q      <= '0;
            lerr_q      <= 1'b0;
            code_q      <= '0;
            len_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            nsym_q  <= nsym_d;
            lerr_q  <= lerr_d;
            if (load) begin
                code_q      <= let_code;
                len_q       <= let_len;
                err_q       <= let_err;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (complete && !load) ovf_q <= 1'b1;
        end
    end

    assign code          = code_q;
    assign len           = len_q;
    assign err           = err_q;
    assign out_valid     = out_valid_q;
    assign ovf           = ovf_q;
    assign current_state = state_q;

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Directed and randomized checks of morse_letter_sequencer against a run-length letter model.
module tb_morse_letter_sequencer;

    localparam int DASH_MIN = 3;
    localparam int GAP_MIN  = 3;
    localparam int MAX_SYMS = 5;
    localparam int CNT_W    = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                key = 1'b0;
    logic                rdy = 1'b0;
    logic [MAX_SYMS-1:0] code;
    logic [2:0]          len;
    logic                err, out_valid, ovf;
    logic [1:0]          current_state;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: raw run lengths and a list of classified symbols.
    int  high_run, low_run;
    bit  syms[$];
    bit  exp_valid, exp_err, exp_ovf;
    int  exp_code, exp_len;

    always #5 clk = ~clk;

    morse_letter_sequencer #(
        .DASH_MIN (DASH_MIN),
        .GAP_MIN  (GAP_MIN),
        .MAX_SYMS (MAX_SYMS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in            (key),
        .code          (code),
        .len           (len),
        .err           (err),
        .out_valid     (out_valid),
        .out_ready     (rdy),
        .ovf           (ovf),
        .current_state (current_state)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        high_run = 0;
        low_run  = 0;
        syms.delete();
        exp_valid = 0;
        exp_err   = 0;
        exp_ovf   = 0;
        exp_code  = 0;
        exp_len   = 0;
    endtask

    task automatic model_step(input bit k, input bit r);
        bit done = 0;
        int c = 0;
        int n;
        bit e;
        if (k) begin
            high_run++;
            low_run = 0;
        end else begin
            if (high_run > 0) begin
                syms.push_back(high_run >= DASH_MIN);
                high_run = 0;
                low_run  = 1;
            end else if (syms.size() > 0) begin
                low_run++;
            end
            if (syms.size() > 0 && low_run >= GAP_MIN) done = 1;
        end
        if (done) begin
            n = (syms.size() > MAX_SYMS) ? MAX_SYMS : syms.size();
            e = syms.size() > MAX_SYMS;
            for (int i = 0; i < n; i++) c += int'(syms[i]) << i;
            syms.delete();
            if (!exp_valid || r) begin
                exp_valid = 1;
                exp_code  = c;
                exp_len   = n;
                exp_err   = e;
            end else begin
                exp_ovf = 1;
            end
        end else if (exp_valid && r) begin
            exp_valid = 0;
        end
    endtask

    function automatic int exp_state();
        if (high_run > 0) return 1;
        if (syms.size() > 0) return 2;
        return 0;
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_state"}, int'(current_state), exp_state());
        check({tag, "_valid"}, int'(out_valid), int'(exp_valid));
        check({tag, "_ovf"}, int'(ovf), int'(exp_ovf));
        check({tag, "_code"}, int'(code), exp_code);
        check({tag, "_len"}, int'(len), exp_len);
        check({tag, "_err"}, int'(err), int'(exp_err));
    endtask

    task automatic cycle(input bit k, input bit r, input string tag);
        key = k;
        rdy = r;
        @(posedge clk);
        model_step(k, r);
        #1;
        compare_all(tag);
    endtask

    task automatic play(input string pat, input bit r, input string tag);
        for (int i = 0; i < pat.len(); i++) cycle(pat[i] == "1", r, tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        model_reset();
        check("rst_state", int'(current_state), 0);
        check("rst_valid", int'(out_valid), 0);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        int ml, sl;
        model_reset();
        #2;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Letter A with handoff on the third low cycle.
        play("1011100", 1'b0, "A");
        check("A_valid_pre", int'(out_valid), 0);
        cycle(1'b0, 1'b0, "A");
        check("A_code", int'(code), 5'b00010);
        check("A_len", int'(len), 2);
        check("A_valid", int'(out_valid), 1);
        cycle(1'b0, 1'b1, "A_drain");
        check("A_drained", int'(out_valid), 0);

        // Letter B held, then E overflows.
        play("111010101000", 1'b0, "B");
        check("B_code", int'(code), 5'b00001);
        check("B_len", int'(len), 4);
        play("1000", 1'b0, "E_ovf");
        check("E_ovf", int'(ovf), 1);
        check("E_held_code", int'(code), 5'b00001);
        check("E_held_len", int'(len), 4);

        @(negedge clk);
        do_reset();

        // Six dots: truncated to five with err.
        play("10101010101000", 1'b0, "six");
        check("six_len", int'(len), 5);
        check("six_code", int'(code), 0);
        check("six_err", int'(err), 1);

        // T completes on the same edge that drains the held letter.
        play("11100", 1'b0, "T");
        cycle(1'b0, 1'b1, "T");
        check("T_valid", int'(out_valid), 1);
        check("T_code", int'(code), 5'b00001);
        check("T_len", int'(len), 1);
        check("T_ovf", int'(ovf), 0);
        cycle(1'b0, 1'b1, "T_drain");

        // Async reset in SPACE after two symbols.
        play("1010", 1'b1, "mid");
        check("mid_state", int'(current_state), 2);
        #2;
        do_reset();
        play("1000", 1'b1, "E_after");
        check("E_after_code", int'(code), 0);
        check("E_after_len", int'(len), 1);

        // Saturating long marks; a two-cycle space continues the letter.
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, "long");
        play("000", 1'b1, "long");
        check("long_code", int'(code), 5'b00001);
        check("long_len", int'(len), 1);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, "long2");
        play("0010", 1'b0, "long2");
        check("long2_valid_pre", int'(out_valid), 1);
        play("00", 1'b1, "long2");
        check("long2_code", int'(code), 5'b00001);
        check("long2_len", int'(len), 2);

        // Random run lengths and random consumer back-pressure.
        for (int n = 0; n < 400; n++) begin
            ml = ($urandom_range(0, 15) == 0) ? 18 : $urandom_range(1, 5);
            sl = $urandom_range(1, 5);
            for (int i = 0; i < ml; i++) cycle(1'b1, $urandom_range(0, 2) != 0, "rnd");
            for (int i = 0; i < sl; i++) cycle(1'b0, $urandom_range(0, 2) != 0, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/morse_letter_sequencer.md
Name: morse_letter_sequencer

Overview:
Sequences the serial mark/space line that the Dash detector classifies, and groups successive dot/dash symbols into complete Morse letters. Measures each high run (mark) and low run (space) on `in`, classifies marks as dot or dash, and detects the inter-letter gap. Hands each finished letter to the downstream decoder through a one-entry valid/ready output register, so the FSM never stalls.

Parameters:
DASH_MIN, 3, mark length in cycles at or above which a mark is a dash; shorter marks are dots
GAP_MIN, 3, consecutive low cycles that terminate a letter
MAX_SYMS, 5, maximum symbols per letter; also the width of `code`
CNT_W, 4, run-length counter width; counters saturate at 2^CNT_W-1 (requires GAP_MIN, DASH_MIN < 2^CNT_W)

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
in  in  1  serial keying line; sampled each rising edge
code  out  MAX_SYMS  letter symbols; bit i = symbol i (0 = dot, 1 = dash); first symbol in bit 0; unused bits 0
len  out  3  number of valid symbols in `code` (1..MAX_SYMS)
err  out  1  letter had more than MAX_SYMS symbols; `code` holds the first MAX_SYMS
out_valid  out  1  output register holds an unconsumed letter
out_ready  in  1  consumer accepts the letter when out_valid && out_ready at a rising edge
ovf  out  1  sticky: a completed letter was dropped because the output register was full
current_state  out  2  FSM state, for debug/observation

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; mark_cnt, space_cnt, the symbol accumulator and the symbol count clear; code=0, len=0, err=0, out_valid=0, ovf=0. Reset mid-letter discards the partial letter and any pending output.
- States (2-bit): IDLE=00, MARK=01, SPACE=10; 11 is illegal and returns to IDLE.
- IDLE:
  - in=1 → MARK with mark_cnt=1.
  - in=0 → stay in IDLE; accumulator stays empty.
- MARK:
  - in=1 → mark_cnt += 1, saturating.
  - in=0 → classify the mark: dash if mark_cnt ≥ DASH_MIN, else dot. If the symbol count < MAX_SYMS, write the symbol at bit[count] and increment the count; otherwise set the letter's err flag and drop the symbol. Go to SPACE with space_cnt=1.
- SPACE:
  - in=1 with space_cnt < GAP_MIN → MARK with mark_cnt=1; the letter continues.
  - in=0 with space_cnt = GAP_MIN-1 → letter complete: hand off to the output register, clear the accumulator, go to IDLE.
  - Otherwise space_cnt += 1.
- GAP_MIN=1 edge case: completion happens on the MARK→SPACE edge itself; the FSM goes directly to IDLE and the letter is handed off on that edge.
- Hand-off latency: out_valid rises on the same edge that samples the GAP_MIN-th low cycle. Zero extra cycles.
- Output register:
  - Loads code/len/err when a letter completes and the register is free, or is being consumed on that same edge (out_valid && out_ready).
  - Back-to-back case (consume and complete on the same edge): the new letter is loaded, out_valid stays 1, nothing is dropped.
  - Full case (out_valid=1, out_ready=0, letter completes): the new letter is dropped, ovf ← 1, and the held letter is unchanged.
  - Consume with no new letter: out_valid ← 0; code/len/err hold their last values.
- ovf is cleared only by rst.
- Held-output rule: code/len/err are stable while out_valid=1 && out_ready=0.
- Long marks: mark_cnt saturates and still classifies as a dash. Long spaces: no effect beyond completion (IDLE absorbs them).

Decomposition:
- Shared package morse_pkg: state typedef (IDLE/MARK/SPACE, 2-bit); constants SYM_DOT=0 and SYM_DASH=1.
- One sub-module, run_len_counter: CNT_W-bit saturating counter with clear-to-1 and enable. Instantiated twice, for mark_cnt and space_cnt.

Test Plan:
1. rst=1 then 0, in: 1,0,1,1,1,0,0,0 → one letter "A": code=00010, len=2, err=0, out_valid rises on the edge sampling the third 0; out_ready=1 clears it next edge.
2. in: 1,1,1,0,1,0,1,0,1,0,0,0 with out_ready held 0 → "B": code=00001, len=4. Then a second letter "E" (1,0,0,0) completes → ovf=1; code/len still 00001/4.
3. Six dots (1,0 ×6) then 0,0 → len=5, code=00000, err=1, out_valid=1.
4. Letter "T" (1,1,1,0,0,0) completes on the same edge out_ready=1 consumes the previous letter → out_valid stays 1, new code=00001, len=1, ovf stays 0.
5. rst pulsed asynchronously in SPACE after two symbols → current_state=00 and out_valid=0 immediately; the following "E" yields code=00000, len=1.
6. Mark of 20 cycles then 0,0,0 → counter saturates; code=00001, len=1 (dash); space of 2 between marks continues the letter, space of 3 ends it.
